// File: rtl/full_adder_checker.sv
// full_adder_checker: response monitor for a 1-bit full adder under test.
// Ports:
//   clk, rst, clear      - clock, sync active-high reset, sync soft clear (same effect)
//   stim_valid, a1/a2/cin - stimulus presented to the adder
//   s, cout              - adder response, DUT_LAT cycles after its stimulus
//   vec_count, err_count - saturating counts of checked and mismatching vectors
//   coverage             - bit {a1,a2,cin} set once that combination was checked
//   fail_seen/fail_vector- sticky first-mismatch flag and its {a1,a2,cin,s,cout}
//   done, pass           - verdict available, and verdict with no errors
module full_adder_checker #(
    parameter int DUT_LAT     = 0,
    parameter int CNT_W       = 16,
    parameter int MIN_VECTORS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             stim_valid,
    input  logic             a1,
    input  logic             a2,
    input  logic             cin,
    input  logic             s,
    input  logic             cout,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       coverage,
    output logic             fail_seen,
    output logic [4:0]       fail_vector,
    output logic             done,
    output logic             pass
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [3:0] aligned;
    logic [1:0] state, state_next;

    generate
        if (DUT_LAT == 0) begin : g_direct
            assign aligned = {stim_valid, a1, a2, cin};
        end else begin : g_pipe
            // Oldest stage sits in the top nibble; it lines up with the current s/cout.
            logic [4*DUT_LAT-1:0] pipe;
            logic [4*DUT_LAT+3:0] shifted;
            assign shifted = {pipe, stim_valid, a1, a2, cin};
            assign aligned = shifted[4*DUT_LAT+3:4*DUT_LAT];
            always_ff @(posedge clk) begin
                if (rst || clear) pipe <= '0;
                else pipe <= shifted[4*DUT_LAT-1:0];
            end
        end
    endgenerate

    logic             compare, exp_s, exp_c, mismatch, reach;
    logic [2:0]       idx;
    logic [CNT_W-1:0] vec_next, err_next;
    logic [7:0]       cov_next;

    assign compare  = aligned[3];
    assign idx      = aligned[2:0];
    assign exp_s    = ^idx;
    assign exp_c    = (idx[2] & idx[1]) | (idx[0] & (idx[2] ^ idx[1]));
    // Case-equality so an X/Z response counts as a mismatch.
    assign mismatch = !((s === exp_s) && (cout === exp_c));
    assign vec_next = (compare && vec_count != '1) ? vec_count + 1'b1 : vec_count;
    assign err_next = (compare && mismatch && err_count != '1) ? err_count + 1'b1 : err_count;
    assign cov_next = compare ? (coverage | (8'd1 << idx)) : coverage;
    assign reach    = (int'(vec_next) >= MIN_VECTORS) && (cov_next == 8'hFF);

    assign state_next = (state == IDLE) ? (compare ? RUN : IDLE) :
                        (state == RUN && reach) ? DONE : state;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_count   <= '0;
            err_count   <= '0;
            coverage    <= '0;
            fail_seen   <= 1'b0;
            fail_vector <= '0;
            state       <= IDLE;
        end else begin
            vec_count <= vec_next;
            err_count <= err_next;
            coverage  <= cov_next;
            state     <= state_next;
            if (compare && mismatch && !fail_seen) begin
                fail_seen   <= 1'b1;
                fail_vector <= {idx, s, cout};
            end
        end
    end

    assign done = (state == DONE);
    assign pass = done && (err_count == '0);
endmodule

// File: tb/tb_full_adder_checker.sv
// tb_full_adder_checker: directed bench for full_adder_checker at latencies 0/2/3 and a narrow-counter build.
module tb_full_adder_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, clear = 1'b0, sv = 1'b0, a1 = 1'b0, a2 = 1'b0, cin = 1'b0;
    logic s0 = 1'b0, c0 = 1'b0;
    logic [5:0] dl = '0;
    int checks = 0, failures = 0;

    function automatic logic [1:0] fa(input logic [2:0] v);
        return {^v, (v[2] & v[1]) | (v[0] & (v[2] ^ v[1]))};
    endfunction

    // Reference correct adder followed by a delay line: 1, 2 and 3 cycle responses.
    always @(posedge clk) dl <= {dl[3:0], fa({a1, a2, cin})};

    logic [15:0] vc0, ec0, vc2, ec2, vc3, ec3;
    logic [2:0]  vcs, ecs;
    logic [7:0]  cv0, cv2, cv3, cvs;
    logic [4:0]  fv0, fv2, fv3, fvs;
    logic        fs0, fs2, fs3, fss, dn0, dn2, dn3, dns, ps0, ps2, ps3, pss;

    full_adder_checker #(.DUT_LAT(0)) u0 (.clk(clk), .rst(rst), .clear(clear), .stim_valid(sv),
        .a1(a1), .a2(a2), .cin(cin), .s(s0), .cout(c0), .vec_count(vc0), .err_count(ec0),
        .coverage(cv0), .fail_seen(fs0), .fail_vector(fv0), .done(dn0), .pass(ps0));
    full_adder_checker #(.DUT_LAT(2)) u2 (.clk(clk), .rst(rst), .clear(clear), .stim_valid(sv),
        .a1(a1), .a2(a2), .cin(cin), .s(dl[3]), .cout(dl[2]), .vec_count(vc2), .err_count(ec2),
        .coverage(cv2), .fail_seen(fs2), .fail_vector(fv2), .done(dn2), .pass(ps2));
    full_adder_checker #(.DUT_LAT(3)) u3 (.clk(clk), .rst(rst), .clear(clear), .stim_valid(sv),
        .a1(a1), .a2(a2), .cin(cin), .s(dl[5]), .cout(dl[4]), .vec_count(vc3), .err_count(ec3),
        .coverage(cv3), .fail_seen(fs3), .fail_vector(fv3), .done(dn3), .pass(ps3));
    full_adder_checker #(.DUT_LAT(0), .CNT_W(3), .MIN_VECTORS(7)) us (.clk(clk), .rst(rst),
        .clear(clear), .stim_valid(sv), .a1(a1), .a2(a2), .cin(cin), .s(s0), .cout(c0),
        .vec_count(vcs), .err_count(ecs), .coverage(cvs), .fail_seen(fss), .fail_vector(fvs),
        .done(dns), .pass(pss));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vec(input logic [2:0] v, input logic vs, input logic vc);
        @(negedge clk);
        sv = 1'b1;
        {a1, a2, cin} = v;
        s0 = vs;
        c0 = vc;
    endtask

    task automatic good(input logic [2:0] v);
        logic [1:0] r;
        r = fa(v);
        vec(v, r[1], r[0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sv = 1'b0;
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        sv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        reset_all();
        chk("reset_vec", vc0, 0);
        chk("reset_cov", cv0, 0);
        chk("reset_done", dn0, 0);
        chk("reset_pass", ps0, 0);

        // Exhaustive, latency 0
        for (int i = 0; i < 8; i++) good(3'(i));
        idle(1);
        chk("lat0_vec", vc0, 8);
        chk("lat0_err", ec0, 0);
        chk("lat0_cov", cv0, 8'hFF);
        chk("lat0_done", dn0, 1);
        chk("lat0_pass", ps0, 1);

        // Exhaustive, latency 3: done exactly 4 cycles after the last stimulus
        reset_all();
        for (int i = 0; i < 8; i++) good(3'(i));
        idle(3);
        chk("lat3_done_early", dn3, 0);
        idle(1);
        chk("lat3_done", dn3, 1);
        chk("lat3_pass", ps3, 1);
        chk("lat3_vec", vc3, 8);
        chk("lat3_cov", cv3, 8'hFF);

        // Injected faults at 011 (cout low) and 111 (s low)
        reset_all();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) vec(3'b011, 1'b0, 1'b0);
            else if (i == 7) vec(3'b111, 1'b0, 1'b1);
            else good(3'(i));
        end
        idle(1);
        chk("fault_err", ec0, 2);
        chk("fault_seen", fs0, 1);
        chk("fault_vector", fv0, 5'b01100);
        chk("fault_done", dn0, 1);
        chk("fault_pass", ps0, 0);

        // Coverage gap: 101 never used
        reset_all();
        for (int i = 0; i < 20; i++) begin
            logic [2:0] v;
            v = 3'(i % 8);
            good(v == 3'b101 ? 3'b110 : v);
        end
        idle(1);
        chk("gap_vec", vc0, 20);
        chk("gap_cov", cv0, 8'hDF);
        chk("gap_done", dn0, 0);
        good(3'b101);
        idle(1);
        chk("gap_fill_done", dn0, 1);
        chk("gap_fill_pass", ps0, 1);

        // Reset mid-run at latency 2 with two stimuli in flight
        reset_all();
        for (int i = 0; i < 5; i++) good(3'(i));
        @(negedge clk);
        chk("mid_vec_before", vc2, 3);
        sv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_vec_zero", vc2, 0);
        chk("mid_cov_zero", cv2, 0);
        chk("mid_err_zero", ec2, 0);
        chk("mid_fail_zero", {fs2, fv2, dn2, ps2}, 0);
        idle(2);
        chk("mid_no_stray", vc2, 0);
        for (int i = 0; i < 8; i++) good(3'(7 - i));
        idle(3);
        chk("mid_final_vec", vc2, 8);
        chk("mid_final_pass", ps2, 1);

        // Stimulus in the clear cycle is dropped, even when it would enter the pipe
        for (int i = 0; i < 3; i++) good(3'(i));
        @(negedge clk);
        sv = 1'b1;
        {a1, a2, cin} = 3'b100;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        sv = 1'b0;
        chk("clear_vec0", vc0, 0);
        idle(3);
        chk("clear_vec2", vc2, 0);
        chk("clear_done2", dn2, 0);

        // X on s counts as a mismatch
        reset_all();
        vec(3'b010, 1'bx, 1'b0);
        idle(1);
        chk("x_err", ec0, 1);
        chk("x_seen", fs0, 1);

        // Saturating 3-bit counters
        reset_all();
        for (int i = 0; i < 10; i++) good(3'(i % 8));
        idle(1);
        chk("sat_vec", vcs, 7);
        chk("sat_done", dns, 1);
        chk("sat_pass", pss, 1);
        for (int i = 0; i < 9; i++) begin
            logic [1:0] r;
            r = fa(3'(i % 8));
            vec(3'(i % 8), ~r[1], r[0]);
        end
        idle(1);
        chk("sat_err", ecs, 7);
        chk("sat_vec_hold", vcs, 7);
        chk("sat_fail_pass", pss, 0);
        chk("sat_fail_done", dns, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/full_adder_checker.md
Name: full_adder_checker

Overview:
- Synthesizable, self-checking response monitor for a 1-bit full adder.
- Stimulus side presents a1/a2/cin with a valid strobe. The DUT's s/cout return DUT_LAT cycles later.
- Block aligns the two, compares against a golden model, and counts vectors and mismatches. It also tracks coverage of all 8 input combinations and raises a pass/fail verdict.
- Sits beside the full adder on board or in simulation as the receiving end of the stimulus stream.

Parameters:
- DUT_LAT, 0, cycles between stimulus and DUT response; legal range 0..7.
- CNT_W, 16, width of the vector and error counters.
- MIN_VECTORS, 8, minimum number of checked vectors before a verdict is given; must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear; same effect as rst on all state.
- stim_valid  in  1  a1/a2/cin valid this cycle.
- a1  in  1  adder operand A.
- a2  in  1  adder operand B.
- cin  in  1  adder carry-in.
- s  in  1  DUT sum, valid DUT_LAT cycles after its stimulus.
- cout  in  1  DUT carry-out, valid DUT_LAT cycles after its stimulus.
- vec_count  out  CNT_W  vectors checked.
- err_count  out  CNT_W  mismatching vectors.
- coverage  out  8  bit {a1,a2,cin} set once that combination has been checked.
- fail_seen  out  1  sticky; set on the first mismatch.
- fail_vector  out  5  {a1,a2,cin,s,cout} of the first mismatch.
- done  out  1  verdict available.
- pass  out  1  done with err_count==0.

Behaviour:
- Reset/clear state: all outputs 0, alignment pipe emptied, FSM in IDLE.
  - rst and clear are interchangeable. Asserting either mid-run discards all in-flight stimuli; no compare occurs for them.
- Alignment pipe: DUT_LAT stages, each holding {valid, a1, a2, cin}.
  - DUT_LAT=0: compare uses the stim_valid/a1/a2/cin presented in the same cycle as s/cout.
  - Otherwise the stage-DUT_LAT output is compared with the current s/cout.
  - Pipe shifts every cycle; there is no backpressure.
  - Back-to-back stim_valid is supported at full rate.
- Compare event: occurs when the aligned valid is 1. Let idx = {a1,a2,cin} aligned.
  - Expected sum = a1^a2^cin. Expected carry = (a1&a2)|(cin&(a1^a2)).
  - Mismatch: s or cout differs from expected.
- Outputs on the clock edge ending a compare cycle (i.e. visible one cycle after the compare):
  - vec_count+1.
  - coverage[idx]=1.
  - On mismatch: err_count+1.
  - On the first mismatch only: fail_seen=1 and fail_vector captured. Later mismatches never overwrite it.
- Counters saturate at 2^CNT_W-1; they never wrap. Saturation of one counter does not stop the other.
- FSM:
  - IDLE: wait for the first compare event. That compare updates counters and the FSM moves to RUN.
  - RUN: keep checking. Enter DONE on the edge where vec_count (updated) ≥ MIN_VECTORS and coverage (updated) == 8'hFF.
  - DONE: done=1; pass = (err_count==0), updated combinationally from registered err_count.
    - Checking continues in DONE; a later mismatch increments err_count and drops pass to 0.
    - The FSM leaves DONE only via rst/clear.
- X/Z on s or cout during a compare is treated as a mismatch.
- A stim_valid arriving in the same cycle as clear is dropped.

Test Plan:
- Exhaustive, correct DUT, DUT_LAT=0: 8 vectors 000..111 back-to-back.
  - Required: vec_count=8, err_count=0, coverage=8'hFF, done=1, pass=1 one cycle after the last vector.
- Same 8 vectors, DUT_LAT=3: responses delayed 3 cycles.
  - Required: identical final values. done rises exactly 4 cycles after the last stim_valid.
- Injected fault, DUT_LAT=0: at vector 011 force cout=0 (expected 1), s=0; later at 111 force s=0.
  - Required: err_count=2, fail_seen=1, fail_vector=5'b01100, pass=0, done=1.
- Coverage gap: 20 vectors never using 101.
  - Required: vec_count=20, coverage=8'hDF, done=0.
  - Then one 101 vector → done=1, pass=1.
- Reset mid-run, DUT_LAT=2: 5 vectors, rst pulsed one cycle while 2 are in flight, then 8 fresh vectors.
  - Required: all outputs 0 after rst; final vec_count=8 with no stray compares.
- Saturation, CNT_W=3: 10 correct vectors covering all combos.
  - Required: vec_count holds at 7, done=1, pass=1.
  - Then 9 faulty vectors → err_count=7, pass=0.
